// File: rtl/sysbus_pkg.sv
// Shared types and constants for the Sysbus arbiter slice.
// Tag layout on the bus is {rw(1), type(4), id(8)}.
package sysbus_pkg;

   localparam int unsigned TAG_W      = 13;
   localparam int unsigned BEATS      = 8;
   localparam int unsigned LINE_BYTES = 64;

   localparam logic       TAG_RW_READ     = 1'b0;
   localparam logic       TAG_RW_WRITE    = 1'b1;
   localparam logic [3:0] TAG_TYPE_MEMORY = 4'h1;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WDATA,
      RESP
   } arb_state_e;

   // Line-align an address by clearing the byte-offset bits.
   function automatic logic [63:0] line_addr(input logic [63:0] a);
      return a & ~64'(LINE_BYTES - 1);
   endfunction

   // Stamp the requesting port index into id[0] of a tag.
   function automatic logic [TAG_W-1:0] port_tag(input logic [TAG_W-1:0] t, input logic port);
      logic [TAG_W-1:0] r;
      r    = t;
      r[0] = port;
      return r;
   endfunction

endpackage

// File: rtl/sysbus_arbiter_if.sv
// Requester-side and Sysbus-side signals of the arbiter.
// The master modport is the arbiter's view; slave is the surrounding core/bus.
interface sysbus_arbiter_if;
   import sysbus_pkg::*;

   logic [1:0]            rq_valid;
   logic [1:0]            rq_write;
   logic [1:0][63:0]      rq_addr;
   logic [1:0][TAG_W-1:0] rq_tag;
   logic [511:0]          rq_wline;
   logic [1:0]            rq_gnt;
   logic [1:0]            rsp_valid;
   logic [63:0]           rsp_data;
   logic                  bus_reqcyc;
   logic [63:0]           bus_req;
   logic [TAG_W-1:0]      bus_reqtag;
   logic                  bus_reqack;
   logic                  bus_respcyc;
   logic [63:0]           bus_resp;
   logic [TAG_W-1:0]      bus_resptag;
   logic                  bus_respack;

   modport master (
      input  rq_valid, rq_write, rq_addr, rq_tag, rq_wline,
      output rq_gnt, rsp_valid, rsp_data,
      output bus_reqcyc, bus_req, bus_reqtag,
      input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
      output bus_respack
   );

   modport slave (
      output rq_valid, rq_write, rq_addr, rq_tag, rq_wline,
      input  rq_gnt, rsp_valid, rsp_data,
      input  bus_reqcyc, bus_req, bus_reqtag,
      output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
      input  bus_respack
   );

endinterface

// File: rtl/sysbus_arbiter_pick.sv
// Two-way request picker: fixed priority to port 1, or round-robin
// (port not granted last wins) when rr_en is set.
module arb_pick (
   input  logic [1:0] valid,
   input  logic       last,
   input  logic       rr_en,
   output logic       winner
);

   // Select the winning port from the current request vector
   always_comb begin
      winner = 1'b0;
      case (valid)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = rr_en ? ~last : 1'b1;
         default: winner = 1'b0;
      endcase
   end

endmodule

// File: rtl/sysbus_arbiter.sv
// Sysbus arbiter: shares the Sysbus master port between fetch (port 0) and
// load/store (port 1). One outstanding transaction; write lines go out as
// 8 beats after the address, read beats are steered to the owner.
// Build option: define SYSBUS_ARB_RR_EN for round-robin arbitration,
// otherwise port 1 has fixed priority.
module sysbus_arbiter
   import sysbus_pkg::*;
(
   input logic              clk,
   input logic              reset,
   sysbus_arbiter_if.master bus
);

   arb_state_e       state_q, state_d;
   logic             owner_q, owner_d;
   logic             write_q, write_d;
   logic             last_q, last_d;
   logic [2:0]       beat_q, beat_d;
   logic [511:0]     wline_q, wline_d;
   logic             reqcyc_q, reqcyc_d;
   logic [63:0]      req_q, req_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [1:0]       gnt;
   logic [1:0]       rsp;
   logic             winner;
   logic             rr_en;

`ifdef SYSBUS_ARB_RR_EN
   assign rr_en = 1'b1;
`else
   assign rr_en = 1'b0;
`endif

   arb_pick u_pick (
      .valid  (bus.rq_valid),
      .last   (last_q),
      .rr_en  (rr_en),
      .winner (winner)
   );

   // State and bus request registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         write_q  <= 1'b0;
         last_q   <= 1'b0;
         beat_q   <= '0;
         wline_q  <= '0;
         reqcyc_q <= 1'b0;
         req_q    <= '0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         write_q  <= write_d;
         last_q   <= last_d;
         beat_q   <= beat_d;
         wline_q  <= wline_d;
         reqcyc_q <= reqcyc_d;
         req_q    <= req_d;
         tag_q    <= tag_d;
      end
   end

   // Next-state, request-phase and write-beat sequencing
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      write_d  = write_q;
      last_d   = last_q;
      beat_d   = beat_q;
      wline_d  = wline_q;
      reqcyc_d = reqcyc_q;
      req_d    = req_q;
      tag_d    = tag_q;
      gnt      = '0;
      case (state_q)
         IDLE: begin
            if (|bus.rq_valid) begin
               state_d  = REQ;
               owner_d  = winner;
               write_d  = bus.rq_write[winner];
               reqcyc_d = 1'b1;
               req_d    = line_addr(bus.rq_addr[winner]);
               tag_d    = port_tag(bus.rq_tag[winner], winner);
            end
         end
         REQ: begin
            if (bus.bus_reqack) begin
               gnt[owner_q] = 1'b1;
               last_d       = owner_q;
               beat_d       = '0;
               if (write_q) begin
                  // Beat 0 is taken straight from the requester so it is on
                  // the bus the cycle after acceptance; the rest come from the
                  // latched copy.
                  state_d = WDATA;
                  wline_d = bus.rq_wline;
                  req_d   = bus.rq_wline[63:0];
               end else begin
                  state_d  = RESP;
                  reqcyc_d = 1'b0;
               end
            end
         end
         WDATA: begin
            if (beat_q == 3'(BEATS - 1)) begin
               state_d  = IDLE;
               reqcyc_d = 1'b0;
               beat_d   = '0;
            end else begin
               beat_d = beat_q + 3'd1;
               req_d  = wline_q[{beat_q + 3'd1, 6'd0} +: 64];
            end
         end
         RESP: begin
            if (bus.bus_respcyc) begin
               if (beat_q == 3'(BEATS - 1)) begin
                  state_d = IDLE;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Route read beats to the owning port with zero latency
   always_comb begin
      rsp = '0;
      if (state_q == RESP && bus.bus_respcyc) begin
         rsp[owner_q] = 1'b1;
      end
   end

   assign bus.rq_gnt      = gnt;
   assign bus.rsp_valid   = rsp;
   assign bus.rsp_data    = bus.bus_resp;
   assign bus.bus_reqcyc  = reqcyc_q;
   assign bus.bus_req     = req_q;
   assign bus.bus_reqtag  = tag_q;
   assign bus.bus_respack = bus.bus_respcyc;

   // A requester must hold its request until granted
   a_valid_held : assert property (@(posedge clk) disable iff (reset)
      (state_q == REQ) |-> bus.rq_valid[owner_q]);

   // Response beats are only expected while a read is outstanding
   a_resp_in_resp : assert property (@(posedge clk) disable iff (reset)
      bus.bus_respcyc |-> (state_q == RESP));

   // Response tag must match the outstanding request
   a_resp_tag : assert property (@(posedge clk) disable iff (reset)
      (bus.bus_respcyc && state_q == RESP) |-> (bus.bus_resptag == tag_q));

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter. Inputs are driven 1 ns after the rising
// edge; outputs are checked on the falling edge.
module tb_sysbus_arbiter;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   sysbus_arbiter_if bus_if ();

   sysbus_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic next_drive();
      @(posedge clk);
      #1;
   endtask

   // Present a request, wait ack_dly cycles in REQ, then ack and check the grant.
   // Returns at the drive point just after the accepting edge.
   task automatic issue(input int port, input logic wr, input logic [63:0] addr,
                        input logic [12:0] tag, input logic [63:0] exp_req,
                        input logic [12:0] exp_tag, input int ack_dly);
      bus_if.rq_valid[port] = 1'b1;
      bus_if.rq_write[port] = wr;
      bus_if.rq_addr[port]  = addr;
      bus_if.rq_tag[port]   = tag;
      next_drive();
      for (int i = 0; i < ack_dly; i++) begin
         @(negedge clk);
         check("reqcyc_hold", bus_if.bus_reqcyc, 1);
         check("req_hold", bus_if.bus_req, exp_req);
         check("gnt_early", bus_if.rq_gnt, 0);
         next_drive();
      end
      bus_if.bus_reqack = 1'b1;
      @(negedge clk);
      check("reqcyc", bus_if.bus_reqcyc, 1);
      check("req_addr", bus_if.bus_req, exp_req);
      check("reqtag", bus_if.bus_reqtag, exp_tag);
      check("gnt", bus_if.rq_gnt, 64'd1 << port);
      next_drive();
      bus_if.bus_reqack     = 1'b0;
      bus_if.rq_valid[port] = 1'b0;
   endtask

   // Deliver n read beats (base+b) with gap idle cycles before each.
   task automatic rd_beats(input int port, input logic [12:0] tag, input logic [63:0] base,
                           input int gap, input int n);
      for (int b = 0; b < n; b++) begin
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("gap_no_rsp", bus_if.rsp_valid, 0);
            next_drive();
         end
         bus_if.bus_respcyc = 1'b1;
         bus_if.bus_resp    = base + 64'(b);
         bus_if.bus_resptag = tag;
         @(negedge clk);
         check("rsp_valid", bus_if.rsp_valid, 64'd1 << port);
         check("rsp_data", bus_if.rsp_data, base + 64'(b));
         check("reqcyc_resp", bus_if.bus_reqcyc, 0);
         next_drive();
         bus_if.bus_respcyc = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int exp_port;
      bus_if.rq_valid    = '0;
      bus_if.rq_write    = '0;
      bus_if.rq_addr     = '0;
      bus_if.rq_tag      = '0;
      bus_if.rq_wline    = '0;
      bus_if.bus_reqack  = 1'b0;
      bus_if.bus_respcyc = 1'b0;
      bus_if.bus_resp    = '0;
      bus_if.bus_resptag = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_reqcyc", bus_if.bus_reqcyc, 0);
      check("rst_req", bus_if.bus_req, 0);
      check("rst_reqtag", bus_if.bus_reqtag, 0);
      check("rst_gnt", bus_if.rq_gnt, 0);
      check("rst_rsp", bus_if.rsp_valid, 0);
      next_drive();
      reset = 1'b0;

      // Port 0 read of 0x1040, ack after 3 cycles
      issue(0, 1'b0, 64'h1040, 13'h105, 64'h1040, 13'h104, 3);
      rd_beats(0, 13'h104, 64'hA0A0_0000_0000_0000, 0, 8);

      // Simultaneous requests: port 1 first, port 0 right after its 8th beat
      bus_if.rq_valid[0] = 1'b1;
      bus_if.rq_addr[0]  = 64'h2000;
      bus_if.rq_tag[0]   = 13'h105;
      issue(1, 1'b0, 64'h3047, 13'h122, 64'h3040, 13'h123, 0);
      rd_beats(1, 13'h123, 64'hB000, 0, 8);
      issue(0, 1'b0, 64'h2000, 13'h105, 64'h2000, 13'h104, 0);
      rd_beats(0, 13'h104, 64'hC000, 0, 8);

      // Both held valid continuously
      bus_if.rq_valid   = 2'b11;
      bus_if.rq_write   = 2'b00;
      bus_if.rq_addr[0] = 64'h4000;
      bus_if.rq_addr[1] = 64'h5000;
      bus_if.rq_tag[0]  = 13'h105;
      bus_if.rq_tag[1]  = 13'h122;
      for (int k = 0; k < 4; k++) begin
`ifdef SYSBUS_ARB_RR_EN
         exp_port = (k % 2 == 0) ? 1 : 0;
`else
         exp_port = 1;
`endif
         if (exp_port == 1) begin
            issue(1, 1'b0, 64'h5000, 13'h122, 64'h5000, 13'h123, 0);
            bus_if.rq_valid[1] = 1'b1;
            rd_beats(1, 13'h123, 64'hD000 + 64'(k * 16), 0, 8);
         end else begin
            issue(0, 1'b0, 64'h4000, 13'h105, 64'h4000, 13'h104, 0);
            bus_if.rq_valid[0] = 1'b1;
            rd_beats(0, 13'h104, 64'hE000 + 64'(k * 16), 0, 8);
         end
      end
      bus_if.rq_valid = '0;

      // Port 1 write line, beats 0x11..0x88; line changed after grant
      for (int i = 0; i < 8; i++) begin
         bus_if.rq_wline[64*i +: 64] = 64'h11 * 64'(i + 1);
      end
      issue(1, 1'b1, 64'h6000, 13'h1140, 64'h6000, 13'h1141, 1);
      bus_if.rq_wline = '0;
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         check("wr_reqcyc", bus_if.bus_reqcyc, 1);
         check("wr_beat", bus_if.bus_req, 64'h11 * 64'(b + 1));
         check("wr_no_rsp", bus_if.rsp_valid, 0);
         next_drive();
      end
      @(negedge clk);
      check("wr_done_reqcyc", bus_if.bus_reqcyc, 0);
      next_drive();

      // Read with 2-cycle gaps, followed immediately by another request
      issue(1, 1'b0, 64'h7000, 13'h122, 64'h7000, 13'h123, 0);
      rd_beats(1, 13'h123, 64'hF000, 2, 8);
      issue(0, 1'b0, 64'h8000, 13'h105, 64'h8000, 13'h104, 0);

      // Reset after the 3rd beat; remaining beats arrive while in reset
      rd_beats(0, 13'h104, 64'h1_0000, 0, 3);
      reset = 1'b1;
      next_drive();
      for (int b = 3; b < 8; b++) begin
         bus_if.bus_respcyc = 1'b1;
         bus_if.bus_resp    = 64'h1_0000 + 64'(b);
         @(negedge clk);
         check("rst_mid_rsp", bus_if.rsp_valid, 0);
         check("rst_mid_ack", bus_if.bus_respack, 1);
         check("rst_mid_reqcyc", bus_if.bus_reqcyc, 0);
         check("rst_mid_req", bus_if.bus_req, 0);
         check("rst_mid_tag", bus_if.bus_reqtag, 0);
         next_drive();
      end
      bus_if.bus_respcyc = 1'b0;
      reset = 1'b0;

      // Full read after reset recovery
      issue(1, 1'b0, 64'h9010, 13'h122, 64'h9000, 13'h123, 1);
      rd_beats(1, 13'h123, 64'h2_0000, 1, 8);
      @(negedge clk);
      check("end_reqcyc", bus_if.bus_reqcyc, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
